// File: rtl/crc32_16_pkg.sv
// Shared constants, types and the CRC-32 word step for the 16-bit CRC checker.
// Build option: CRC32_16_CHK_FINAL_XOR_EN selects the residue for an inverted FCS.
package crc32_16_pkg;

  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

`ifdef CRC32_16_CHK_FINAL_XOR_EN
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
`else
  localparam logic [31:0] CRC_RESIDUE = 32'h00000000;
`endif

  typedef enum logic {
    IDLE,
    FRAME
  } state_t;

  typedef struct packed {
    logic ok;
    logic short_frm;
    logic abort;
  } status_t;

  // MSB-first update of the CRC register with one 16-bit word
  function automatic logic [31:0] crc32_16_step(input logic [31:0] crc,
                                                input logic [15:0] data);
    logic [31:0] c;
    c = crc;
    for (int unsigned i = 0; i < 16; i++) begin
      if (c[31] ^ data[15 - i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else                      c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_16.sv
// Combinational CRC-32 next-state for one 16-bit word (poly 0x04C11DB7, MSB-first).
module crc32_16
  import crc32_16_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [15:0] data,
  output logic [31:0] crc_next
);

  always_comb begin
    crc_next = crc32_16_step(crc, data);
  end

endmodule

// File: rtl/crc32_16_check.sv
// Receive-side CRC-32 checker for 16-bit word frames: strips the 2-word FCS,
// forwards payload with sop/eop, reports ok/short/abort. Option: CRC32_16_CHK_FINAL_XOR_EN.
module crc32_16_check
  import crc32_16_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  logic             in_sop_i,
  input  logic             in_eop_i,
  input  logic [15:0]      in_data_i,
  output logic             out_valid_o,
  output logic             out_sop_o,
  output logic             out_eop_o,
  output logic [15:0]      out_data_o,
  output logic             done_o,
  output logic             crc_ok_o,
  output logic             short_o,
  output logic             abort_o,
  output logic [LEN_W-1:0] len_o
);

  state_t           state_q, state_d;
  logic [31:0]      crc_q, crc_seed, crc_next;
  logic [15:0]      dl_new_q, dl_old_q;
  logic [1:0]       fill_q;
  logic             first_q;
  logic [LEN_W-1:0] cnt_q, cnt_inc, len_d;
  logic             start, in_frame, frame_word, eop_ev, abort_ev, emit, done_ev;
  status_t          status_d;

  crc32_16 u_crc (
    .crc      (crc_seed),
    .data     (in_data_i),
    .crc_next (crc_next)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (in_valid_i && in_sop_i && !in_eop_i) state_d = FRAME;
      FRAME: if (in_valid_i && in_eop_i)              state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_frame   = (state_q == FRAME);
    start      = in_valid_i & in_sop_i;
    frame_word = in_valid_i & in_frame & ~in_sop_i;
    abort_ev   = start & in_frame;
    eop_ev     = in_valid_i & in_eop_i & (start | in_frame);
    emit       = frame_word & (fill_q == 2'd2);
    done_ev    = eop_ev | abort_ev;
    crc_seed   = start ? CRC_INIT : crc_q;
    cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + LEN_W'(1);

    // sop&eop while in a frame reports the abort and the new short frame in one pulse
    status_d.abort     = abort_ev;
    status_d.short_frm = eop_ev & (start | (fill_q != 2'd2));
    status_d.ok        = eop_ev & ~start & (fill_q == 2'd2) & (crc_next == CRC_RESIDUE);

    if (abort_ev)   len_d = cnt_q;
    else if (start) len_d = '0;
    else if (emit)  len_d = cnt_inc;
    else            len_d = cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      crc_q       <= CRC_INIT;
      dl_new_q    <= '0;
      dl_old_q    <= '0;
      fill_q      <= '0;
      first_q     <= 1'b0;
      cnt_q       <= '0;
      out_valid_o <= 1'b0;
      out_sop_o   <= 1'b0;
      out_eop_o   <= 1'b0;
      out_data_o  <= '0;
      done_o      <= 1'b0;
      crc_ok_o    <= 1'b0;
      short_o     <= 1'b0;
      abort_o     <= 1'b0;
      len_o       <= '0;
    end else begin
      out_valid_o <= emit;
      out_sop_o   <= emit & first_q;
      out_eop_o   <= emit & eop_ev;
      if (emit) out_data_o <= dl_old_q;

      done_o   <= done_ev;
      crc_ok_o <= status_d.ok;
      short_o  <= status_d.short_frm;
      abort_o  <= status_d.abort;
      len_o    <= done_ev ? len_d : '0;

      if (start || frame_word) crc_q <= crc_next;

      if (start) begin
        dl_new_q <= in_data_i;
        fill_q   <= in_eop_i ? 2'd0 : 2'd1;
        first_q  <= 1'b1;
        cnt_q    <= '0;
      end else if (frame_word) begin
        // the two newest words are held back: they are the FCS if eop follows
        if (in_eop_i) begin
          fill_q <= '0;
        end else begin
          dl_old_q <= dl_new_q;
          dl_new_q <= in_data_i;
          if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
        end
        if (emit) begin
          first_q <= 1'b0;
          cnt_q   <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_crc32_16_check.sv
// Directed bench for crc32_16_check: payload/status scoreboard against an independent CRC model.
module tb_crc32_16_check;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_sop, in_eop;
  logic [15:0]      in_data;
  logic             out_valid, out_sop, out_eop, done, crc_ok, short_o, abort_o;
  logic [15:0]      out_data;
  logic [LEN_W-1:0] len;

  always #5 clk = ~clk;

  crc32_16_check #(.LEN_W(LEN_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_sop_i    (in_sop),
    .in_eop_i    (in_eop),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_sop_o   (out_sop),
    .out_eop_o   (out_eop),
    .out_data_o  (out_data),
    .done_o      (done),
    .crc_ok_o    (crc_ok),
    .short_o     (short_o),
    .abort_o     (abort_o),
    .len_o       (len)
  );

  typedef struct { logic [15:0] d; logic sop, eop; } ow_t;
  typedef struct { logic ok, sh, ab; int len; int cyc; } st_t;

  ow_t         got_out[$], exp_out[$];
  st_t         got_st[$], exp_st[$];
  logic [15:0] pay[$], frm[$];
  int          n_chk = 0, n_fail = 0, ncyc = 0;

  function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [15:0] d);
    logic fb;
    for (int b = 15; b >= 0; b--) begin
      fb = c[31] ^ d[b];
      c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
    end
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    ncyc++;
    if (out_valid) got_out.push_back('{out_data, out_sop, out_eop});
    if (done) got_st.push_back('{crc_ok, short_o, abort_o, int'(len), ncyc});
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_word(input logic [15:0] d, input logic sop, input logic eop);
    in_valid = 1'b1; in_sop = sop; in_eop = eop; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic build(input bit bad);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    frm = pay;
    foreach (pay[i]) c = crc_model(c, pay[i]);
`ifdef CRC32_16_CHK_FINAL_XOR_EN
    c = ~c;
`endif
    frm.push_back(c[31:16]);
    frm.push_back(c[15:0] ^ {15'd0, bad});
  endtask

  // drives frm; abort_len >= 0 means the first word also aborts a frame in progress
  task automatic send(input int gap_max, input bit exp_ok, input int abort_len);
    int n, np;
    n  = frm.size();
    np = n - 2;
    for (int i = 0; i < np; i++) exp_out.push_back('{frm[i], i == 0, i == np - 1});
    for (int i = 0; i < n; i++) begin
      if (gap_max > 0 && i > 0) idle($urandom_range(gap_max, 0));
      drive_word(frm[i], i == 0, i == n - 1);
      if (i == 0 && abort_len >= 0) exp_st.push_back('{1'b0, n < 3, 1'b1, abort_len, ncyc + 1});
      else if (i == n - 1) exp_st.push_back('{exp_ok, n < 3, 1'b0, (np > 0) ? np : 0, ncyc + 1});
    end
  endtask

  task automatic drain();
    int m;
    idle(4);
    check("out_count", got_out.size(), exp_out.size());
    m = (got_out.size() < exp_out.size()) ? got_out.size() : exp_out.size();
    for (int i = 0; i < m; i++) begin
      check("out_data", got_out[i].d, exp_out[i].d);
      check("out_sop", got_out[i].sop, exp_out[i].sop);
      check("out_eop", got_out[i].eop, exp_out[i].eop);
    end
    check("done_count", got_st.size(), exp_st.size());
    m = (got_st.size() < exp_st.size()) ? got_st.size() : exp_st.size();
    for (int i = 0; i < m; i++) begin
      check("crc_ok", got_st[i].ok, exp_st[i].ok);
      check("short", got_st[i].sh, exp_st[i].sh);
      check("abort", got_st[i].ab, exp_st[i].ab);
      check("len", got_st[i].len, exp_st[i].len);
      check("done_cycle", got_st[i].cyc, exp_st[i].cyc);
    end
    got_out.delete(); exp_out.delete(); got_st.delete(); exp_st.delete();
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0;
    idle(3);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sop", out_sop, 0);
    check("rst_out_eop", out_eop, 0);
    check("rst_out_data", out_data, 0);
    check("rst_done", done, 0);
    check("rst_crc_ok", crc_ok, 0);
    check("rst_short", short_o, 0);
    check("rst_abort", abort_o, 0);
    check("rst_len", len, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);
    drain();

    // good frame, then the same frame with a corrupted FCS
    pay = '{16'h3132, 16'h3334, 16'h3536, 16'h3738};
    build(1'b0); send(0, 1'b1, -1); drain();
    build(1'b1); send(0, 1'b0, -1); drain();

    // short frames: single word, and eop on the second word
    frm = '{16'h1234}; send(0, 1'b0, -1); drain();
    frm = '{16'hAAAA, 16'h5555}; send(0, 1'b0, -1); drain();

    // minimal frame: one payload word carries both sop and eop
    pay = '{16'hBEEF}; build(1'b0); send(0, 1'b1, -1); drain();

    // abort after 3 words of a 6-word frame, new frame starts on the sop word
    pay = '{16'h1111, 16'h2222, 16'h3333, 16'h4444}; build(1'b0);
    drive_word(frm[0], 1'b1, 1'b0);
    drive_word(frm[1], 1'b0, 1'b0);
    drive_word(frm[2], 1'b0, 1'b0);
    exp_out.push_back('{frm[0], 1'b1, 1'b0});
    pay = '{16'hCAFE, 16'h0001, 16'hF00D}; build(1'b0);
    send(0, 1'b1, 1); drain();

    // idle gaps between words
    pay = '{16'h3132, 16'h3334, 16'h3536, 16'h3738};
    build(1'b0); send(3, 1'b1, -1); drain();

    // reset mid-frame discards it; the next frame is clean
    pay = '{16'h0A0B, 16'h0C0D, 16'h0E0F, 16'h1011, 16'h1213}; build(1'b0);
    drive_word(frm[0], 1'b1, 1'b0);
    drive_word(frm[1], 1'b0, 1'b0);
    drive_word(frm[2], 1'b0, 1'b0);
    exp_out.push_back('{frm[0], 1'b1, 1'b0});
    rst = 1'b1; idle(2); rst = 1'b0;
    pay = '{16'h5A5A, 16'hA5A5}; build(1'b0); send(0, 1'b1, -1); drain();

    // back-to-back frames of random length
    for (int f = 0; f < 100; f++) begin
      n = $urandom_range(64, 3);
      pay.delete();
      for (int i = 0; i < n - 2; i++) pay.push_back(16'($urandom));
      build(1'b0);
      send(0, 1'b1, -1);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
